// File: rtl/decoder_scan_pkg.sv
// rtl/decoder_scan_pkg.sv - shared state encoding and select-code helpers for the decoder scan sequencer
package decoder_scan_pkg;

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] RUN       = 1'b1;
  localparam logic [2:0] LAST_CODE = 3'd7;

  // Returns {found, code}: the first code at or above base (wrapping upward) whose mask bit is clear.
  function automatic logic [3:0] first_from(input logic [2:0] base, input logic [7:0] mask);
    logic [3:0] r;
    logic [2:0] c;
    r = 4'b0000;
    for (int k = int'(LAST_CODE); k >= 0; k--) begin
      c = base + 3'(k);
      if (!mask[c]) r = {1'b1, c};
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_scan_sequencer_dwell_counter.sv
// rtl/decoder_scan_sequencer_dwell_counter.sv - free-running dwell counter, tick on the last clock of each dwell
module dwell_counter #(
  parameter int DWELL = 4,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr || tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/decoder_scan_sequencer.sv
// rtl/decoder_scan_sequencer.sv - walks 3:8 decoder select codes with a per-code dwell; SCAN_SKIP_EN adds skip_mask
module decoder_scan_sequencer
  import decoder_scan_pkg::*;
#(
  parameter int DWELL = 4,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       one_shot,
`ifdef SCAN_SKIP_EN
  input  logic [7:0] skip_mask,
`endif
  output logic       sel0,
  output logic       sel1,
  output logic       sel2,
  output logic       dec_en,
  output logic       busy,
  output logic       wrap,
  output logic       done
);

  logic [0:0] state;
  logic [2:0] sel;
  logic       mode;
  logic       wrap_q;
  logic       done_q;
  logic       tick;
  logic       clr;
  logic [7:0] mask;
  logic [3:0] entry;
  logic [3:0] adv;
  logic       sweep_end;

`ifdef SCAN_SKIP_EN
  assign mask = skip_mask;
`else
  assign mask = 8'h00;
`endif

  assign entry = first_from(3'd0, mask);
  assign adv   = first_from(sel + 3'd1, mask);
  // A sweep ends whenever the next live code does not lie above the current one.
  assign sweep_end = (adv[2:0] <= sel);

  assign clr = (state != RUN) || stop;

  dwell_counter #(
    .DWELL (DWELL),
    .CNT_W (CNT_W)
  ) u_dwell (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      sel    <= 3'd0;
      mode   <= 1'b0;
      wrap_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      if (state == IDLE) begin
        if (start && !stop && entry[3]) begin
          state <= RUN;
          sel   <= entry[2:0];
          mode  <= one_shot;
        end
      end else begin
        if (stop) begin
          state <= IDLE;
          sel   <= 3'd0;
        end else if (tick) begin
          if (!adv[3]) begin
            // Every code masked off mid-scan: nothing left to drive.
            state <= IDLE;
            sel   <= 3'd0;
          end else if (sweep_end && mode) begin
            state  <= IDLE;
            sel    <= 3'd0;
            done_q <= 1'b1;
          end else begin
            sel    <= adv[2:0];
            wrap_q <= sweep_end;
          end
        end
      end
    end
  end

  assign sel0   = sel[0];
  assign sel1   = sel[1];
  assign sel2   = sel[2];
  assign dec_en = (state == RUN);
  assign busy   = (state == RUN);
  assign wrap   = wrap_q;
  assign done   = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// tb/tb_decoder_scan_sequencer.sv - directed plus randomized checks of two DWELL variants against a timing model
module tb_decoder_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       one_shot = 1'b0;
  logic [7:0] skip_mask = 8'h00;

  logic s0a, s1a, s2a, ena, bsa, wra, dna;
  logic s0b, s1b, s2b, enb, bsb, wrb, dnb;

  int n_checks = 0;
  int n_pass = 0;

  // Model state per instance: 0 -> DWELL 4, 1 -> DWELL 2
  bit         m_run[2];
  int         m_t[2];
  bit         m_mode[2];
  bit         m_done[2];
  logic [7:0] m_mask[2];

  always #5 clk = ~clk;

  decoder_scan_sequencer #(.DWELL(4), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
`ifdef SCAN_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .sel0(s0a), .sel1(s1a), .sel2(s2a), .dec_en(ena), .busy(bsa), .wrap(wra), .done(dna)
  );

  decoder_scan_sequencer #(.DWELL(2), .CNT_W(4)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .one_shot(one_shot),
`ifdef SCAN_SKIP_EN
    .skip_mask(skip_mask),
`endif
    .sel0(s0b), .sel1(s1b), .sel2(s2b), .dec_en(enb), .busy(bsb), .wrap(wrb), .done(dnb)
  );

  function automatic int dw(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  function automatic int nfree(input logic [7:0] m);
    int n = 0;
    for (int k = 0; k < 8; k++) if (!m[k]) n++;
    return n;
  endfunction

  function automatic logic [2:0] nth_free(input logic [7:0] m, input int idx);
    logic [2:0] r = 3'd0;
    int c = 0;
    for (int k = 0; k < 8; k++) begin
      if (!m[k]) begin
        if (c == idx) r = 3'(k);
        c++;
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] expect_out(input int i);
    int n, p;
    logic w;
    if (m_run[i]) begin
      n = nfree(m_mask[i]);
      p = (m_t[i] / dw(i)) % n;
      w = !m_mode[i] && (m_t[i] > 0) && (m_t[i] % (n * dw(i)) == 0);
      return {nth_free(m_mask[i], p), 1'b1, 1'b1, w, 1'b0};
    end
    return {3'b000, 1'b0, 1'b0, 1'b0, m_done[i]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_t[i] = 0; m_mode[i] = 0; m_done[i] = 0; m_mask[i] = 8'h00;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 0;
      if (!m_run[i]) begin
        if (start && !stop && skip_mask != 8'hFF) begin
          m_run[i] = 1; m_t[i] = 0; m_mode[i] = one_shot; m_mask[i] = skip_mask;
        end
      end else if (stop) begin
        m_run[i] = 0;
      end else begin
        m_t[i]++;
        if (m_mode[i] && m_t[i] == nfree(m_mask[i]) * dw(i)) begin
          m_run[i] = 0;
          m_done[i] = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed={sel,en,busy,wrap,done}=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/dwell4"}, {s2a, s1a, s0a, ena, bsa, wra, dna}, expect_out(0));
    chk({tag, "/dwell2"}, {s2b, s1b, s0b, enb, bsb, wrb, dnb}, expect_out(1));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_all(tag);
  endtask

  initial begin
    model_reset();
    // Reset state and quiet idle after release
    #2;
    check_all("reset_async");
    cyc("reset_held");
    rst = 1'b0;
    for (int k = 0; k < 10; k++) cyc("idle_after_reset");

    // One-shot sweep: 32 clocks at DWELL 4, 16 at DWELL 2, then done
    one_shot = 1'b1; start = 1'b1;
    cyc("oneshot_entry");
    start = 1'b0;
    for (int k = 0; k < 36; k++) cyc("oneshot_sweep");

    // Continuous scan with periodic wraps
    one_shot = 1'b0; start = 1'b1;
    cyc("cont_entry");
    start = 1'b0;
    for (int k = 0; k < 40; k++) cyc("cont_scan");
    stop = 1'b1;
    cyc("cont_stop");
    stop = 1'b0;

    // Stop while DWELL-4 instance shows code 3
    start = 1'b1;
    cyc("stop_entry");
    start = 1'b0;
    for (int k = 0; k < 13; k++) cyc("stop_run");
    chk("sel_is_3_before_stop", {s2a, s1a, s0a, ena, bsa, wra, dna}, {3'd3, 4'b1100});
    stop = 1'b1;
    cyc("stop_at_3");
    start = 1'b1;
    cyc("start_and_stop");
    cyc("start_and_stop_2");
    start = 1'b0; stop = 1'b0;

    // Asynchronous reset mid-dwell at code 5
    start = 1'b1;
    cyc("rst_entry");
    start = 1'b0;
    for (int k = 0; k < 21; k++) cyc("rst_run");
    chk("sel_is_5_before_rst", {s2a, s1a, s0a, ena, bsa, wra, dna}, {3'd5, 4'b1100});
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_mid_dwell");
    cyc("rst_mid_dwell_held");
    rst = 1'b0;

`ifdef SCAN_SKIP_EN
    skip_mask = 8'b1010_1010; one_shot = 1'b1; start = 1'b1;
    cyc("skip_entry");
    start = 1'b0;
    for (int k = 0; k < 20; k++) cyc("skip_sweep");
    skip_mask = 8'hFF; start = 1'b1;
    for (int k = 0; k < 4; k++) cyc("skip_all_masked");
    start = 1'b0; skip_mask = 8'h00;
    cyc("skip_restore");
`endif

    // Randomized traffic
    for (int k = 0; k < 600; k++) begin
      start    = ($urandom % 4) == 0;
      stop     = ($urandom % 20) == 0;
      one_shot = $urandom % 2;
`ifdef SCAN_SKIP_EN
      if (!m_run[0] && !m_run[1] && ($urandom % 6) == 0) skip_mask = 8'($urandom);
`endif
      cyc("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
